// File: rtl/gate_bist.sv
// gate_bist: built-in self-test for a 2-input, 1-bit gate. Sweeps all four input
// vectors PASSES times, samples o_in after SETTLE cycles and compares it against TRUTH.
module gate_bist #(
  parameter logic [3:0] TRUTH  = 4'b0111,
  parameter int         SETTLE = 1,
  parameter int         PASSES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       x,
  output logic       y,
  input  logic       o_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [3:0] fail_vec
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [7:0] PASS_LAST   = 8'(PASSES - 1);

  state_t     state, state_nxt;
  logic [1:0] idx, idx_nxt;
  logic [3:0] settle_cnt, settle_cnt_nxt;
  logic [7:0] pass_cnt, pass_cnt_nxt;
  logic [7:0] err_nxt;
  logic [3:0] fail_nxt;
  logic       x_nxt, y_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= 2'd0;
      settle_cnt <= 4'd0;
      pass_cnt   <= 8'd0;
      err_count  <= 8'd0;
      fail_vec   <= 4'd0;
      x          <= 1'b0;
      y          <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      settle_cnt <= settle_cnt_nxt;
      pass_cnt   <= pass_cnt_nxt;
      err_count  <= err_nxt;
      fail_vec   <= fail_nxt;
      x          <= x_nxt;
      y          <= y_nxt;
    end
  end

  // settle_cnt runs 0..SETTLE-1 so each vector spends exactly SETTLE cycles in DRIVE
  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    settle_cnt_nxt = settle_cnt;
    pass_cnt_nxt   = pass_cnt;
    err_nxt        = err_count;
    fail_nxt       = fail_vec;
    x_nxt          = x;
    y_nxt          = y;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt      = DRIVE;
          idx_nxt        = 2'd0;
          settle_cnt_nxt = 4'd0;
          pass_cnt_nxt   = 8'd0;
          err_nxt        = 8'd0;
          fail_nxt       = 4'd0;
          x_nxt          = 1'b0;
          y_nxt          = 1'b0;
        end
      end
      DRIVE: begin
        if (settle_cnt == SETTLE_LAST) begin
          settle_cnt_nxt = 4'd0;
          state_nxt      = SAMPLE;
        end else begin
          settle_cnt_nxt = settle_cnt + 4'd1;
        end
      end
      SAMPLE: begin
        if (o_in != TRUTH[idx]) begin
          if (err_count != 8'hFF) err_nxt = err_count + 8'd1;
          fail_nxt[idx] = 1'b1;
        end
        if (idx != 2'd3) begin
          idx_nxt   = idx + 2'd1;
          x_nxt     = idx_nxt[0];
          y_nxt     = idx_nxt[1];
          state_nxt = DRIVE;
        end else if (pass_cnt != PASS_LAST) begin
          idx_nxt      = 2'd0;
          pass_cnt_nxt = pass_cnt + 8'd1;
          x_nxt        = 1'b0;
          y_nxt        = 1'b0;
          state_nxt    = DRIVE;
        end else begin
          x_nxt     = 1'b0;
          y_nxt     = 1'b0;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == DRIVE) || (state == SAMPLE);
  assign done = (state == DONE);
  assign pass = done && (err_count == 8'd0);

endmodule

// File: doc/gate_bist.md
# gate_bist

Synthesizable built-in self-test engine for a 2-input, 1-bit logic gate; it is the hardware counterpart of our gate-level benches. On `start` it drives every input combination into the gate under test, samples the gate's output after a settle delay, and compares it against a parameterized expected truth table. It sits beside any 1-bit gate instance (nand, and, or, xor, …) and reports pass/fail, an error count, and which vectors failed.

## Interface
- `TRUTH`, 4'b0111, expected output per vector index i = {y,x}; bit i is the expected `o_in` (default = NAND)
- `SETTLE`, 1, cycles `x`/`y` are held before sampling; legal range 1..15
- `PASSES`, 1, number of full 4-vector sweeps per run; legal range 1..255
- `clk`  input  1  single clock; all logic on rising edge
- `rst_n`  input  1  reset: synchronous, active-low
- `start`  input  1  run request; sampled only in IDLE or DONE
- `x`  output  1  registered stimulus to gate input x
- `y`  output  1  registered stimulus to gate input y
- `o_in`  input  1  gate output under test
- `busy`  output  1  high while sweeping
- `done`  output  1  high from run completion until next accepted `start` or reset
- `pass`  output  1  valid when `done`; 1 iff `err_count` == 0
- `err_count`  output  8  mismatches this run, saturating at 255
- `fail_vec`  output  4  sticky; bit i set if vector i mismatched in any pass

## Operation
- States: IDLE, DRIVE, SAMPLE, DONE.
- Reset (`rst_n`=0 at an edge): state IDLE; `x`=`y`=`busy`=`done`=`pass`=0; `err_count`=0; `fail_vec`=0; vector index, settle counter, pass counter = 0. Reset wins over every other event, including mid-sweep.
- IDLE/DONE + `start`=1: clear `err_count`, `fail_vec`, `done`, `pass`; index=0, pass counter=0; go DRIVE with `x`=0, `y`=0.
- Vector order i = 0,1,2,3: `x`=i[0], `y`=i[1] → (x,y) = 00, 10, 01, 11.
- DRIVE: hold `x`/`y`; settle counter counts 1..SETTLE; after SETTLE cycles go SAMPLE.
- SAMPLE (one cycle, `x`/`y` still held): if `o_in` != TRUTH[i], increment `err_count` (saturate at 255) and set `fail_vec[i]`. Then:
  - i<3: i+1, load next `x`/`y`, go DRIVE.
  - i=3 and pass counter < PASSES-1: i=0, pass counter+1, go DRIVE.
  - i=3 and last pass: go DONE; `x`=`y`=0.
- DONE: `done`=1, `pass`=(`err_count`==0); results stable until accepted `start` or reset.
- `start` while `busy` is ignored; no effect on the run.
- `x`/`y` are 0 in IDLE and DONE.
- `busy`=1 exactly in DRIVE and SAMPLE.

## Timing
- `start` sampled at edge k: `busy`=1 and first vector on `x`/`y` from after edge k until after edge k+4·(SETTLE+1)·PASSES; `done`=1 after that edge.
- Per vector: SETTLE DRIVE cycles + 1 SAMPLE cycle; `o_in` is compared at the edge ending SAMPLE, i.e. SETTLE+1 cycles after `x`/`y` changed.
- Defaults (SETTLE=1, PASSES=1): 8 busy cycles; `done` visible 9 cycles after the `start` edge.
- `err_count` and `fail_vec` update on the edge ending the SAMPLE cycle; they are valid mid-run but final only when `done`=1.
- `start` in DONE: next cycle `done`=`pass`=0, `busy`=1, counters cleared; back-to-back runs have no idle gap.

## Test plan
- Bench NAND on `x`,`y`→`o_in`, defaults, `start` pulse → `busy` 8 cycles, x/y sequence 00,10,01,11 each held 2 cycles; `done`=1, `pass`=1, `err_count`=0, `fail_vec`=0000.
- `o_in` stuck at 1, defaults → `done` at cycle 9, `pass`=0, `err_count`=1, `fail_vec`=1000.
- Bench AND gate with TRUTH=0111, PASSES=3 → `err_count`=12, `fail_vec`=1111, busy 24 cycles.
- SETTLE=3, NAND gate with 2-cycle registered delay → `pass`=1; same gate with SETTLE=1 → `pass`=0, `err_count`≥1.
- `rst_n`=0 during third vector → next cycle IDLE, all outputs 0; subsequent `start` runs clean with `pass`=1.
- `start` held high through busy then pulsed in DONE → mid-run `start` ignored (run length unchanged), DONE `start` clears results and restarts next cycle.
